// File: rtl/alu_muldiv.sv
// CPU ALU: single-cycle add/sub (binary and BCD), logic and rotate ops, plus
// iterative unsigned multiply/divide behind a start/busy/done handshake.
module alu_muldiv #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned ENABLE_MULDIV = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             rdy,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] ai,
    input  logic [WIDTH-1:0] bi,
    input  logic             ci,
    input  logic             bcd,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] hi,
    output logic             co,
    output logic             v,
    output logic             z,
    output logic             n,
    output logic             hc,
    output logic             busy,
    output logic             done
);
    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned WP1 = WIDTH + 1;
    localparam int unsigned CW  = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_ROL = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_ROR = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1001;

    logic [WIDTH-1:0] b_eff, bcd_res, res_c;
    logic [WIDTH:0]   bin_sum;
    logic [4:0]       dig;
    logic             dc, bcd_hc, co_c, v_c, hc_c, is_md_c;

    logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
    logic             is_div;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0] nxt_hi_c, nxt_lo_c;

    // Single-cycle result; BCD digits ripple low to high with decimal correction.
    always_comb begin
        b_eff   = (op == OP_SUB) ? ~bi : bi;
        bin_sum = {1'b0, ai} + {1'b0, b_eff} + WP1'(ci);
        bcd_res = '0;
        bcd_hc  = 1'b0;
        dc      = ci;
        dig     = '0;
        for (int i = 0; i < int'(NIB); i++) begin
            dig = {1'b0, ai[4*i +: 4]} + {1'b0, b_eff[4*i +: 4]} + 5'(dc);
            if (op == OP_SUB) begin
                dc = dig[4];
                if (!dig[4]) dig = dig - 5'd6;
            end else begin
                dc = (dig > 5'd9);
                if (dc) dig = dig + 5'd6;
            end
            bcd_res[4*i +: 4] = dig[3:0];
            if (i == 0) bcd_hc = dc;
        end

        res_c   = ai;
        co_c    = ci;
        v_c     = 1'b0;
        hc_c    = 1'b0;
        is_md_c = (ENABLE_MULDIV != 0) && ((op == OP_MUL) || (op == OP_DIV));
        case (op)
            OP_ADD, OP_SUB: begin
                v_c = (ai[WIDTH-1] == b_eff[WIDTH-1]) && (bin_sum[WIDTH-1] != ai[WIDTH-1]);
                if (bcd) begin
                    res_c = bcd_res;
                    co_c  = dc;
                    hc_c  = bcd_hc;
                end else begin
                    res_c = bin_sum[WIDTH-1:0];
                    co_c  = bin_sum[WIDTH];
                    hc_c  = ai[4] ^ b_eff[4] ^ bin_sum[4];
                end
            end
            OP_ROL: begin
                res_c = {ai[WIDTH-2:0], ci};
                co_c  = ai[WIDTH-1];
            end
            OP_OR:  res_c = ai | bi;
            OP_AND: res_c = ai & bi;
            OP_XOR: res_c = ai ^ bi;
            OP_ROR: begin
                res_c = {ci, ai[WIDTH-1:1]};
                co_c  = ai[0];
            end
            default: ;
        endcase
    end

    // One shift-add (MUL) or restoring shift-subtract (DIV) step.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (is_div) begin
            if (!div_diff[WIDTH]) begin
                nxt_hi_c = div_diff[WIDTH-1:0];
                nxt_lo_c = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi_c = div_shift[WIDTH-1:0];
                nxt_lo_c = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            nxt_hi_c = mul_sum[WIDTH:1];
            nxt_lo_c = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out    <= '0;
            hi     <= '0;
            co     <= 1'b0;
            v      <= 1'b0;
            z      <= 1'b0;
            n      <= 1'b0;
            hc     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            cnt    <= '0;
        end else if (clk_en && rdy) begin
            if (busy) begin
                acc_hi <= nxt_hi_c;
                acc_lo <= nxt_lo_c;
                cnt    <= cnt - CW'(1);
                // Last step: publish result and flags together with done.
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    out  <= nxt_lo_c;
                    hi   <= nxt_hi_c;
                    hc   <= 1'b0;
                    if (is_div) begin
                        co <= 1'b0;
                        v  <= (opnd == '0);
                        n  <= nxt_lo_c[WIDTH-1];
                        z  <= (nxt_lo_c == '0);
                    end else begin
                        co <= (nxt_hi_c != '0);
                        v  <= 1'b0;
                        n  <= nxt_hi_c[WIDTH-1];
                        z  <= ({nxt_hi_c, nxt_lo_c} == '0);
                    end
                end
            end else if (start) begin
                if (is_md_c) begin
                    busy   <= 1'b1;
                    done   <= 1'b0;
                    cnt    <= CW'(WIDTH);
                    acc_hi <= '0;
                    acc_lo <= ai;
                    opnd   <= bi;
                    is_div <= (op == OP_DIV);
                end else begin
                    done <= 1'b1;
                    out  <= res_c;
                    hi   <= '0;
                    co   <= co_c;
                    v    <= v_c;
                    hc   <= hc_c;
                    n    <= res_c[WIDTH-1];
                    z    <= (res_c == '0);
                end
            end else begin
                done <= 1'b0;
            end
        end
    end
endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised next-generation CPU ALU with configurable width.
- Keeps the add/subtract (binary and BCD), logic and shift operations, now with a start/busy/done handshake.
- Adds iterative unsigned multiply and divide engines taking WIDTH enabled cycles.
- Sits between the CPU register file/sequencer and the flag register; the sequencer stalls on busy.

Parameters:
WIDTH, 8, data width in bits; multiple of 4, minimum 8.
ENABLE_MULDIV, 1, 0 removes the MUL/DIV datapath; those opcodes then behave as reserved.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-high reset
clk_en  input  1  clock enable; no state changes when low
rdy  input  1  CPU ready; no state changes when low
start  input  1  launch operation; sampled on enabled edges only while busy=0
op  input  4  operation select
ai  input  WIDTH  operand A
bi  input  WIDTH  operand B
ci  input  1  carry in (active-high carry / no-borrow)
bcd  input  1  decimal mode for ADD/SUB
out  output  WIDTH  result (low half of product, quotient)
hi  output  WIDTH  high half of product / remainder; 0 for all other ops
co  output  1  carry out
v  output  1  overflow
z  output  1  zero
n  output  1  negative
hc  output  1  carry out of nibble 0
busy  output  1  multi-cycle operation in progress
done  output  1  result valid pulse, one enabled cycle wide

Behaviour:
- Enabled edge: rising clk with clk_en=1 and rdy=1. Other edges hold all state, including done and busy.
- Reset (any time, including mid-MUL/DIV): out, hi, co, v, z, n, hc, busy and done all 0. The iteration counter clears and any operation is aborted.
- Operands ai, bi, ci and bcd are captured at the accept edge and may change afterwards.

Opcodes:
- 0000 ADD: ai+bi+ci.
- 0001 SUB: ai+~bi+ci.
- 0010 ROL: {ai,ci}; co=ai[W-1].
- 0011 PASS: ai.
- 0100 OR, 0101 AND, 0110 XOR.
- 0111 ROR: {ci,ai[W-1:1]}; co=ai[0].
- 1000 MUL, 1001 DIV.
- Others: reserved, same as PASS.

Single-cycle ops:
- Accepted when start=1 and busy=0 on an enabled edge.
- Result and flags are registered on that edge; done=1 from that edge until the next enabled edge.
- start held high re-launches every enabled cycle; done then stays high.

ADD/SUB binary:
- co = carry out of bit W-1.
- v = signed overflow.
- hc = carry out of bit 3.

ADD/SUB BCD (bcd=1):
- Each nibble is computed serially, low to high, with decimal correction.
- ADD: if nibble sum >9, add 6 and carry 1.
- SUB: if nibble borrows, subtract 6 (mod 16) and carry 0.
- co = final decimal carry; hc = decimal carry out of nibble 0.
- v is computed from the uncorrected binary result.
- Invalid-BCD operands: result is defined by the same per-nibble rule, with no error flag.

Flags by operation:
- Logic/PASS/reserved: co=ci, v=0, hc=0.
- All single-cycle ops: n=out[W-1], z=(out==0), hi=0.

MUL/DIV:
- Accept edge: busy=1, done=0, counter=WIDTH.
- One shift-add (MUL) or restoring shift-subtract (DIV) step per enabled edge.
- On the WIDTH-th enabled edge after accept, all of the following happen together:
  - out and hi are registered;
  - busy drops to 0;
  - done=1 for one enabled cycle.
- Latency accept→done is WIDTH enabled edges; a new start is accepted on the done edge+1 at the earliest.
- start while busy=1 is ignored.
- MUL: {hi,out}=ai*bi unsigned.
  - co = (hi!=0); v=0; hc=0.
  - n = hi[W-1]; z = ({hi,out}==0).
- DIV: out=ai/bi, hi=ai%bi.
  - co=0; v=0; n=out[W-1]; z=(out==0).
- DIV with bi=0: same latency; out = all ones, hi=ai, v=1.
- Flags keep their previous values while busy=1.

Test Plan:
- Binary ADD, WIDTH=8: ai=7F, bi=01, ci=0, start → out=80, co=0, v=1, n=1, z=0, hc=1, done=1 for one enabled cycle.
- BCD: ADD ai=58, bi=46, ci=1, bcd=1 → out=05, co=1. SUB ai=42, bi=13, ci=1 → out=29, co=1, hc=0.
- ROR ai=81, ci=1 → out=C0, co=1. ROL ai=80, ci=0 → out=00, co=1, z=1.
- MUL ai=FF, bi=FF → busy high for 8 enabled edges, then hi=FE, out=01, co=1, done pulse.
  - A second start mid-operation is ignored.
  - clk_en low for 3 cycles mid-operation stretches latency by exactly 3.
- DIV ai=C8 (200), bi=07 → out=1C, hi=04, v=0. DIV ai=55, bi=00 → out=FF, hi=55, v=1, latency 8.
- Assert reset at the 4th enabled edge of a MUL → all outputs 0 immediately, busy=0. A following ADD 01+01 → out=02 normally.
